// File: rtl/row_window_sequencer.sv
// Raster pixel stream -> circular line-buffer writes plus 3x3 window row/column descriptors.
// Optional feature macro: ROW_WINDOW_STALL_STATS_EN (adds a saturating stall_count output).
module row_window_sequencer #(
   parameter int PIX_BITS  = 8,
   parameter int IMG_WIDTH = 640,
   parameter int NUM_ROWS  = 3,
   parameter int ROW_BITS  = 2,
   parameter int COL_BITS  = 10
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [PIX_BITS-1:0] pixel_in,
   input  logic                pixel_valid,
   input  logic                frame_start,
   output logic                pixel_ready,
   input  logic                out_ready,
   output logic                mem_wr_en,
   output logic [ROW_BITS-1:0] mem_wr_row,
   output logic [COL_BITS-1:0] mem_wr_col,
   output logic [PIX_BITS-1:0] mem_wr_data,
   output logic                win_valid,
   output logic [ROW_BITS-1:0] win_top_row,
   output logic [ROW_BITS-1:0] win_mid_row,
   output logic [ROW_BITS-1:0] win_bot_row,
   output logic [COL_BITS-1:0] win_col,
   output logic                row_done
`ifdef ROW_WINDOW_STALL_STATS_EN
   ,
   output logic [15:0]         stall_count
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
   localparam logic [ROW_BITS:0]   ROWS_W   = (ROW_BITS + 1)'(NUM_ROWS);

   state_t              state, state_nxt;
   logic [ROW_BITS-1:0] wr_row, wr_row_nxt, eff_row, row_inc, mid_row, top_row;
   logic [COL_BITS-1:0] wr_col, wr_col_nxt, eff_col;
   logic [1:0]          rows_filled, rows_filled_nxt, filled_base;
   logic [ROW_BITS:0]   row_sum, mid_sum, top_sum;
   logic                accept, do_write, row_end, win_load;

   // Ready is held low while reset is asserted so no pixel is taken during reset.
   assign pixel_ready = n_rst & ((state != STREAM) | out_ready | ~win_valid);
   assign accept      = pixel_valid & pixel_ready;

   // An accepted frame_start overrides the counters for this very pixel.
   assign eff_row     = frame_start ? '0 : wr_row;
   assign eff_col     = frame_start ? '0 : wr_col;
   assign filled_base = frame_start ? 2'd0 : rows_filled;
   assign do_write    = accept & (frame_start | (state != IDLE));
   assign row_end     = (eff_col == LAST_COL);
   assign win_load    = accept & ~frame_start & (state == STREAM) & (eff_col >= COL_BITS'(2));

   assign row_sum = {1'b0, eff_row} + (ROW_BITS + 1)'(1);
   assign row_inc = (row_sum == ROWS_W) ? '0 : row_sum[ROW_BITS-1:0];
   assign mid_sum = {1'b0, wr_row} + (ROW_BITS + 1)'(NUM_ROWS - 1);
   assign top_sum = {1'b0, wr_row} + (ROW_BITS + 1)'(NUM_ROWS - 2);
   assign mid_row = (mid_sum >= ROWS_W) ? ROW_BITS'(mid_sum - ROWS_W) : mid_sum[ROW_BITS-1:0];
   assign top_row = (top_sum >= ROWS_W) ? ROW_BITS'(top_sum - ROWS_W) : top_sum[ROW_BITS-1:0];

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no latch is inferred.
      state_nxt       = state;
      wr_row_nxt      = wr_row;
      wr_col_nxt      = wr_col;
      rows_filled_nxt = rows_filled;
      if (do_write) begin
         rows_filled_nxt = filled_base;
         if (row_end) begin
            wr_col_nxt = '0;
            wr_row_nxt = row_inc;
            if (filled_base != 2'd2) rows_filled_nxt = filled_base + 2'd1;
         end else begin
            wr_col_nxt = eff_col + COL_BITS'(1);
            wr_row_nxt = eff_row;
         end
         if (frame_start)
            state_nxt = FILL;
         else if ((state == FILL) && row_end && (rows_filled_nxt == 2'd2))
            state_nxt = STREAM;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
      if (!n_rst) begin
         state       <= IDLE;
         wr_row      <= '0;
         wr_col      <= '0;
         rows_filled <= 2'd0;
      end else begin
         state       <= state_nxt;
         wr_row      <= wr_row_nxt;
         wr_col      <= wr_col_nxt;
         rows_filled <= rows_filled_nxt;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mem_wr_en   <= 1'b0;
         mem_wr_row  <= '0;
         mem_wr_col  <= '0;
         mem_wr_data <= '0;
         row_done    <= 1'b0;
         win_valid   <= 1'b0;
         win_top_row <= '0;
         win_mid_row <= '0;
         win_bot_row <= '0;
         win_col     <= '0;
      end else begin
         mem_wr_en <= do_write;
         row_done  <= do_write & row_end;
         if (do_write) begin
            mem_wr_row  <= eff_row;
            mem_wr_col  <= eff_col;
            mem_wr_data <= pixel_in;
         end
         // Single-entry skid: a load is only possible when the slot is free or draining.
         if (accept & frame_start) begin
            win_valid <= 1'b0;
         end else if (win_load) begin
            win_valid   <= 1'b1;
            win_col     <= eff_col - COL_BITS'(1);
            win_bot_row <= wr_row;
            win_mid_row <= mid_row;
            win_top_row <= top_row;
         end else if (out_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

`ifdef ROW_WINDOW_STALL_STATS_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         stall_count <= 16'd0;
      else if (accept & frame_start)
         stall_count <= 16'd0;
      else if (pixel_valid & ~pixel_ready & (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_row_window_sequencer.sv
// Randomized bench for row_window_sequencer against a frame-index reference model.
module tb_row_window_sequencer;

   localparam int PIX_BITS  = 8;
   localparam int IMG_WIDTH = 8;
   localparam int NUM_ROWS  = 3;
   localparam int ROW_BITS  = 2;
   localparam int COL_BITS  = 3;

   logic                clk = 1'b0;
   logic                n_rst;
   logic [PIX_BITS-1:0] pixel_in;
   logic                pixel_valid;
   logic                frame_start;
   logic                pixel_ready;
   logic                out_ready;
   logic                mem_wr_en;
   logic [ROW_BITS-1:0] mem_wr_row;
   logic [COL_BITS-1:0] mem_wr_col;
   logic [PIX_BITS-1:0] mem_wr_data;
   logic                win_valid;
   logic [ROW_BITS-1:0] win_top_row, win_mid_row, win_bot_row;
   logic [COL_BITS-1:0] win_col;
   logic                row_done;
`ifdef ROW_WINDOW_STALL_STATS_EN
   logic [15:0]         stall_count;
`endif

   row_window_sequencer #(
      .PIX_BITS(PIX_BITS), .IMG_WIDTH(IMG_WIDTH), .NUM_ROWS(NUM_ROWS),
      .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)
   ) dut (
      .clk(clk), .n_rst(n_rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
      .frame_start(frame_start), .pixel_ready(pixel_ready), .out_ready(out_ready),
      .mem_wr_en(mem_wr_en), .mem_wr_row(mem_wr_row), .mem_wr_col(mem_wr_col),
      .mem_wr_data(mem_wr_data), .win_valid(win_valid), .win_top_row(win_top_row),
      .win_mid_row(win_mid_row), .win_bot_row(win_bot_row), .win_col(win_col),
      .row_done(row_done)
`ifdef ROW_WINDOW_STALL_STATS_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int top;
      int mid;
      int bot;
      int col;
   } win_t;

   // Reference model: pixel index n within the current frame, plus pending windows.
   win_t                exp_q[$];
   bit                  in_frame;
   int                  n;
   bit                  exp_wr_en, exp_row_done;
   int                  exp_wr_row, exp_wr_col;
   logic [PIX_BITS-1:0] exp_wr_data;
   int                  exp_stall;

   int n_checks, n_fail;
   int dut_win_cnt, dut_rd_cnt, dut_wr_cnt, ready_low_cnt;

   task automatic model_reset();
      in_frame  = 1'b0;
      n         = 0;
      exp_q.delete();
      exp_wr_en = 1'b0;
      exp_stall = 0;
   endtask

   // One clock of stimulus; model update and per-cycle comparisons inline.
   task automatic step(input bit v, input bit fs, input bit ordy);
      logic [PIX_BITS-1:0] d;
      bit   exp_ready, acc, streaming;
      int   row, col;
      win_t w;
      d           = PIX_BITS'($urandom);
      pixel_valid = v;
      frame_start = fs;
      pixel_in    = d;
      out_ready   = ordy;
      @(negedge clk);
      streaming = in_frame && (n >= 2 * IMG_WIDTH);
      exp_ready = !streaming || ordy || (exp_q.size() == 0);
      n_checks++;
      if (pixel_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL pixel_ready: got %b expected %b (n=%0d)", pixel_ready, exp_ready, n);
      end
      if (pixel_ready !== 1'b1) ready_low_cnt++;
      if (win_valid === 1'b1 && ordy) dut_win_cnt++;
      acc = v && exp_ready;
      if (v && !exp_ready && exp_stall != 65535) exp_stall++;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0 && ordy) exp_q.delete(0);
      exp_wr_en    = 1'b0;
      exp_row_done = 1'b0;
      if (acc) begin
         if (fs) begin
            in_frame  = 1'b1;
            n         = 0;
            exp_stall = 0;
            exp_q.delete();
         end
         if (in_frame) begin
            row          = n / IMG_WIDTH;
            col          = n % IMG_WIDTH;
            exp_wr_en    = 1'b1;
            exp_wr_row   = row % NUM_ROWS;
            exp_wr_col   = col;
            exp_wr_data  = d;
            exp_row_done = (col == IMG_WIDTH - 1);
            if (row >= 2 && col >= 2) begin
               w.bot = row % NUM_ROWS;
               w.mid = (row - 1) % NUM_ROWS;
               w.top = (row - 2) % NUM_ROWS;
               w.col = col - 1;
               exp_q.push_back(w);
            end
            n++;
         end
      end
      if (mem_wr_en === 1'b1) dut_wr_cnt++;
      if (row_done === 1'b1) dut_rd_cnt++;
      n_checks++;
      if (mem_wr_en !== exp_wr_en) begin
         n_fail++;
         $display("FAIL mem_wr_en: got %b expected %b (n=%0d)", mem_wr_en, exp_wr_en, n);
      end
      if (exp_wr_en) begin
         n_checks++;
         if ({mem_wr_row, mem_wr_col, mem_wr_data} !==
             {ROW_BITS'(exp_wr_row), COL_BITS'(exp_wr_col), exp_wr_data}) begin
            n_fail++;
            $display("FAIL mem_write: got row %0d col %0d data %h expected row %0d col %0d data %h",
                     mem_wr_row, mem_wr_col, mem_wr_data, exp_wr_row, exp_wr_col, exp_wr_data);
         end
      end
      n_checks++;
      if (row_done !== exp_row_done) begin
         n_fail++;
         $display("FAIL row_done: got %b expected %b (n=%0d)", row_done, exp_row_done, n);
      end
      n_checks++;
      if (win_valid !== (exp_q.size() != 0)) begin
         n_fail++;
         $display("FAIL win_valid: got %b expected %b (n=%0d)", win_valid, exp_q.size() != 0, n);
      end
      if (exp_q.size() != 0) begin
         w = exp_q[0];
         n_checks++;
         if ({win_top_row, win_mid_row, win_bot_row, win_col} !==
             {ROW_BITS'(w.top), ROW_BITS'(w.mid), ROW_BITS'(w.bot), COL_BITS'(w.col)}) begin
            n_fail++;
            $display("FAIL window: got t/m/b %0d/%0d/%0d col %0d expected %0d/%0d/%0d col %0d",
                     win_top_row, win_mid_row, win_bot_row, win_col, w.top, w.mid, w.bot, w.col);
         end
      end
`ifdef ROW_WINDOW_STALL_STATS_EN
      n_checks++;
      if (stall_count !== 16'(exp_stall)) begin
         n_fail++;
         $display("FAIL stall_count: got %0d expected %0d", stall_count, exp_stall);
      end
`endif
   endtask

   task automatic test_reset();
      n_rst       = 1'b0;
      pixel_valid = 1'b0;
      frame_start = 1'b0;
      pixel_in    = '0;
      out_ready   = 1'b0;
      model_reset();
      #12;
      n_checks++;
      if ({pixel_ready, mem_wr_en, mem_wr_row, mem_wr_col, mem_wr_data, win_valid,
           win_top_row, win_mid_row, win_bot_row, win_col, row_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready %b wr_en %b win_valid %b row_done %b expected all 0",
                  pixel_ready, mem_wr_en, win_valid, row_done);
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (pixel_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: got %b expected 1", pixel_ready);
      end
   endtask

   task automatic test_fill_stream();
      int w0, r0, p0;
      w0 = dut_win_cnt; r0 = dut_rd_cnt; p0 = dut_wr_cnt;
      step(1, 1, 1);
      for (int i = 1; i < 5 * IMG_WIDTH; i++) step(1, 0, 1);
      step(0, 0, 1);
      n_checks++;
      if (dut_rd_cnt - r0 != 5) begin
         n_fail++;
         $display("FAIL fill_row_done_count: got %0d expected 5", dut_rd_cnt - r0);
      end
      n_checks++;
      if (dut_win_cnt - w0 != 18) begin
         n_fail++;
         $display("FAIL fill_window_count: got %0d expected 18", dut_win_cnt - w0);
      end
      n_checks++;
      if (dut_wr_cnt - p0 != 40) begin
         n_fail++;
         $display("FAIL fill_write_count: got %0d expected 40", dut_wr_cnt - p0);
      end
   endtask

   task automatic test_backpressure();
      int w0, p0;
      for (int i = 0; i < 3; i++) step(1, 0, 1);
      w0 = dut_win_cnt; p0 = dut_wr_cnt; ready_low_cnt = 0;
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      n_checks++;
      if (ready_low_cnt != 4) begin
         n_fail++;
         $display("FAIL bp_ready_low: got %0d cycles expected 4", ready_low_cnt);
      end
      step(1, 0, 1);
      n_checks++;
      if (dut_win_cnt - w0 != 1) begin
         n_fail++;
         $display("FAIL bp_release: got %0d windows expected 1", dut_win_cnt - w0);
      end
      n_checks++;
      if (dut_wr_cnt - p0 != 1) begin
         n_fail++;
         $display("FAIL bp_writes: got %0d expected 1", dut_wr_cnt - p0);
      end
      step(0, 0, 1);
   endtask

   task automatic test_frame_restart();
      int w0;
      step(1, 1, 1);
      for (int i = 1; i < 3 * IMG_WIDTH + 4; i++) step(1, 0, 1);
      step(1, 1, 1);
      n_checks++;
      if ({mem_wr_en, mem_wr_row, mem_wr_col, win_valid} !== {1'b1, ROW_BITS'(0), COL_BITS'(0), 1'b0}) begin
         n_fail++;
         $display("FAIL restart_write: got en %b row %0d col %0d win_valid %b expected 1/0/0/0",
                  mem_wr_en, mem_wr_row, mem_wr_col, win_valid);
      end
      w0 = dut_win_cnt;
      for (int i = 1; i < 2 * IMG_WIDTH; i++) step(1, 0, 1);
      step(0, 0, 1);
      n_checks++;
      if (dut_win_cnt != w0) begin
         n_fail++;
         $display("FAIL restart_fill_windows: got %0d expected 0", dut_win_cnt - w0);
      end
      for (int i = 0; i < IMG_WIDTH; i++) step(1, 0, 1);
      step(0, 0, 1);
      n_checks++;
      if (dut_win_cnt - w0 != 6) begin
         n_fail++;
         $display("FAIL restart_row2_windows: got %0d expected 6", dut_win_cnt - w0);
      end
   endtask

   task automatic test_random();
      step(1, 1, 1);
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6);
      step(0, 0, 1);
   endtask

   task automatic test_reset_mid();
      int p0;
      step(1, 1, 1);
      for (int i = 0; i < 10; i++) step(1, 0, 1);
      pixel_valid = 1'b1;
      #2;
      n_rst = 1'b0;
      #1;
      n_checks++;
      if ({pixel_ready, mem_wr_en, mem_wr_row, mem_wr_col, mem_wr_data, win_valid,
           win_top_row, win_mid_row, win_bot_row, win_col, row_done} !== '0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got ready %b wr_en %b win_valid %b row_done %b expected all 0",
                  pixel_ready, mem_wr_en, win_valid, row_done);
      end
      model_reset();
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      p0 = dut_wr_cnt;
      for (int i = 0; i < 6; i++) step(1, 0, 1);
      n_checks++;
      if (dut_wr_cnt != p0) begin
         n_fail++;
         $display("FAIL idle_discard: got %0d writes expected 0", dut_wr_cnt - p0);
      end
      step(1, 1, 1);
      for (int i = 0; i < 30; i++) step(1, 0, $urandom_range(0, 1) == 1);
      step(0, 0, 1);
   endtask

`ifdef ROW_WINDOW_STALL_STATS_EN
   task automatic test_stall_stats();
      step(1, 1, 1);
      for (int i = 1; i < 2 * IMG_WIDTH + 3; i++) step(1, 0, 1);
      for (int i = 0; i < 10; i++) step(1, 0, 0);
      n_checks++;
      if (stall_count !== 16'd10) begin
         n_fail++;
         $display("FAIL stall_ten: got %0d expected 10", stall_count);
      end
      step(1, 1, 1);
      n_checks++;
      if (stall_count !== 16'd0) begin
         n_fail++;
         $display("FAIL stall_clear: got %0d expected 0", stall_count);
      end
      for (int i = 1; i < 2 * IMG_WIDTH + 3; i++) step(1, 0, 1);
      for (int i = 0; i < 70000; i++) step(1, 0, 0);
      n_checks++;
      if (stall_count !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL stall_saturate: got %h expected ffff", stall_count);
      end
      step(0, 0, 1);
   endtask
`endif

   initial begin
      n_checks = 0; n_fail = 0;
      dut_win_cnt = 0; dut_rd_cnt = 0; dut_wr_cnt = 0; ready_low_cnt = 0;
      test_reset();
      test_fill_stream();
      test_backpressure();
      test_frame_restart();
      test_random();
      test_reset_mid();
`ifdef ROW_WINDOW_STALL_STATS_EN
      test_stall_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
